// File: rtl/count_wrap_if.sv
// Bundle of the counter-monitor signals: upstream count and controls in,
// event pulses, wrap count, PWM and alarm status out.
interface count_wrap_if #(
  parameter int CNT_W  = 6,
  parameter int WRAP_W = 8
);
  logic [CNT_W-1:0]  count_in;
  logic [CNT_W-1:0]  cmp_val;
  logic [WRAP_W-1:0] wrap_limit;
  logic              alarm_ack;
  logic              wrap_pulse;
  logic              restart_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              pwm_out;
  logic              alarm;
  logic              overrun;
  logic              err_jump;

  modport master (
    output count_in, cmp_val, wrap_limit, alarm_ack,
    input  wrap_pulse, restart_pulse, wrap_count, pwm_out, alarm, overrun, err_jump
  );

  modport slave (
    input  count_in, cmp_val, wrap_limit, alarm_ack,
    output wrap_pulse, restart_pulse, wrap_count, pwm_out, alarm, overrun, err_jump
  );
endinterface

// File: rtl/count_wrap_monitor.sv
// Watches a 0..MOD_MAX modulus counter: flags wraps, restarts and illegal jumps,
// counts wraps against a limit with an acknowledged alarm, and drives a PWM compare.
module count_wrap_monitor #(
  parameter int CNT_W   = 6,
  parameter int MOD_MAX = 46,
  parameter int WRAP_W  = 8
) (
  input  logic       clk,
  input  logic       rst,
  count_wrap_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ALARM, OVERRUN} state_t;

  localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MOD_MAX);

  logic [CNT_W-1:0]  prev_cnt;
  logic              valid;
  state_t            state_q, state_d;
  logic              wrap_q, restart_q, pwm_q, err_q;
  logic [WRAP_W-1:0] wrap_count_q;

  logic              out_of_range, is_wrap, is_restart, is_legal, limit_hit;
  logic [CNT_W:0]    prev_inc;
  logic [WRAP_W-1:0] wc_inc;

  // Sample classification against the previous cycle's count.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    out_of_range = 1'b0;
    prev_inc     = '0;
    is_wrap      = 1'b0;
    is_restart   = 1'b0;
    is_legal     = 1'b1;
    wc_inc       = '0;
    limit_hit    = 1'b0;

    out_of_range = (bus.count_in > MAX_V);
    prev_inc     = {1'b0, prev_cnt} + {{CNT_W{1'b0}}, 1'b1};
    is_wrap      = valid && (prev_cnt == MAX_V) && (bus.count_in == '0);
    is_restart   = valid && (bus.count_in == '0) && (prev_cnt != MAX_V) && (prev_cnt != '0);
    is_legal     = !valid || is_wrap || is_restart || (bus.count_in == prev_cnt) ||
                   (({1'b0, bus.count_in} == prev_inc) && (prev_cnt < MAX_V));
    wc_inc       = wrap_count_q + {{(WRAP_W-1){1'b0}}, 1'b1};
    limit_hit    = is_wrap && (bus.wrap_limit != '0) && (wc_inc == bus.wrap_limit);
  end

  // Alarm FSM: an ack arriving with a fresh limit event keeps the alarm up
  // without escalating to overrun.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (limit_hit) state_d = ALARM;
      ALARM: begin
        if (bus.alarm_ack && !limit_hit)      state_d = IDLE;
        else if (limit_hit && !bus.alarm_ack) state_d = OVERRUN;
      end
      OVERRUN: if (bus.alarm_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev_cnt     <= '0;
      valid        <= 1'b0;
      state_q      <= IDLE;
      wrap_q       <= 1'b0;
      restart_q    <= 1'b0;
      pwm_q        <= 1'b0;
      err_q        <= 1'b0;
      wrap_count_q <= '0;
    end else begin
      prev_cnt  <= bus.count_in;
      valid     <= 1'b1;
      state_q   <= state_d;
      wrap_q    <= is_wrap;
      restart_q <= is_restart;
      pwm_q     <= (bus.count_in < bus.cmp_val);
      if (out_of_range || !is_legal) err_q <= 1'b1;
      if (limit_hit || is_restart)   wrap_count_q <= '0;
      else if (is_wrap)              wrap_count_q <= wc_inc;
    end
  end

  assign bus.wrap_pulse    = wrap_q;
  assign bus.restart_pulse = restart_q;
  assign bus.wrap_count    = wrap_count_q;
  assign bus.pwm_out       = pwm_q;
  assign bus.alarm         = (state_q != IDLE);
  assign bus.overrun       = (state_q == OVERRUN);
  assign bus.err_jump      = err_q;

endmodule
